// File: rtl/enc_conditioner_pkg.sv
// Shared types and quadrature decode helpers for the encoder conditioning stage.
package enc_conditioner_pkg;

  localparam logic [1:0] GRAY_00 = 2'b00;
  localparam logic [1:0] GRAY_10 = 2'b10;
  localparam logic [1:0] GRAY_11 = 2'b11;
  localparam logic [1:0] GRAY_01 = 2'b01;

  typedef enum logic {
    ST_UNPRIMED = 1'b0,
    ST_PRIMED   = 1'b1
  } prime_state_t;

  typedef struct packed {
    logic step;
    logic dir_fwd;
    logic err;
  } quad_t;

  // Position of an {A,B} pair along the forward cycle 00->10->11->01.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    logic [1:0] pos;
    case (ab)
      GRAY_00: pos = 2'd0;
      GRAY_10: pos = 2'd1;
      GRAY_11: pos = 2'd2;
      default: pos = 2'd3;
    endcase
    return pos;
  endfunction

  function automatic quad_t quad_decode(input logic [1:0] old_ab, input logic [1:0] new_ab);
    quad_t      q;
    logic [1:0] delta;
    q     = '0;
    delta = gray_pos(new_ab) - gray_pos(old_ab);
    case (delta)
      2'd1: begin
        q.step    = 1'b1;
        q.dir_fwd = 1'b1;
      end
      2'd3:    q.step = 1'b1;
      2'd2:    q.err  = 1'b1;
      default: q      = '0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/enc_conditioner_if.sv
// Pin-side and decoded-side signal bundle of enc_conditioner.
// err_count exists only when ENC_ERR_COUNT_EN is defined.
interface enc_conditioner_if #(
  parameter int NUM_ENC = 3
);
  logic [NUM_ENC-1:0] enc_a_in;
  logic [NUM_ENC-1:0] enc_b_in;
  logic [NUM_ENC-1:0] enc_a_out;
  logic [NUM_ENC-1:0] enc_b_out;
  logic [NUM_ENC-1:0] step;
  logic [NUM_ENC-1:0] dir;
  logic [NUM_ENC-1:0] err;
`ifdef ENC_ERR_COUNT_EN
  logic [8*NUM_ENC-1:0] err_count;

  modport master (
    output enc_a_in, enc_b_in,
    input  enc_a_out, enc_b_out, step, dir, err, err_count
  );
  modport slave (
    input  enc_a_in, enc_b_in,
    output enc_a_out, enc_b_out, step, dir, err, err_count
  );
`else
  modport master (
    output enc_a_in, enc_b_in,
    input  enc_a_out, enc_b_out, step, dir, err
  );
  modport slave (
    input  enc_a_in, enc_b_in,
    output enc_a_out, enc_b_out, step, dir, err
  );
`endif
endinterface

// File: rtl/enc_conditioner_debounce.sv
// One encoder pin: synchroniser chain, stable-tick counter and debounced output register.
module enc_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_TICKS    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  input  logic i_tick,
  input  logic i_primed,
  input  logic i_load,
  output logic o_sync,
  output logic o_out,
  output logic o_upd
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [7:0]             r_cnt;
  logic                   r_out;
  logic                   w_diff;

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_out  = r_out;
  assign w_diff = (o_sync != r_out);
  // Asserted on the cycle the output register takes the synced value.
  assign o_upd  = i_primed && i_tick && w_diff && (r_cnt == 8'(DB_TICKS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_out  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      if (i_load) begin
        r_out <= o_sync;
        r_cnt <= '0;
      end else if (!i_primed || !w_diff) begin
        r_cnt <= '0;
      end else if (o_upd) begin
        r_out <= o_sync;
        r_cnt <= '0;
      end else if (i_tick) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/enc_conditioner.sv
// Encoder input conditioner: shared prescaler, per-pin debounce, per-channel priming and x4 decode.
// Optional saturating per-channel error counters under ENC_ERR_COUNT_EN.
module enc_conditioner
  import enc_conditioner_pkg::*;
#(
  parameter int NUM_ENC     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE    = 16,
  parameter int DB_TICKS    = 4
) (
  input logic               clk,
  input logic               reset,
  enc_conditioner_if.slave  bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]      r_pre;
  logic               w_tick;
  logic [NUM_ENC-1:0] w_sync_a, w_sync_b, w_out_a, w_out_b, w_upd_a, w_upd_b;
  logic [NUM_ENC-1:0] w_primed, w_load, w_chg;
  logic [NUM_ENC-1:0] r_prev_a, r_prev_b, r_step, r_dir, r_err;
  prime_state_t       r_state [NUM_ENC];
  logic [7:0]         r_pcnt  [NUM_ENC];
  quad_t              w_quad  [NUM_ENC];

  assign w_tick = (r_pre == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!reset || w_tick) r_pre <= '0;
    else                  r_pre <= r_pre + PW'(1);
  end

  for (genvar g = 0; g < NUM_ENC; g++) begin : g_ch
    enc_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_TICKS(DB_TICKS)) u_db_a (
      .clk(clk), .reset(reset), .i_pin(bus.enc_a_in[g]), .i_tick(w_tick),
      .i_primed(w_primed[g]), .i_load(w_load[g]),
      .o_sync(w_sync_a[g]), .o_out(w_out_a[g]), .o_upd(w_upd_a[g])
    );
    enc_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_TICKS(DB_TICKS)) u_db_b (
      .clk(clk), .reset(reset), .i_pin(bus.enc_b_in[g]), .i_tick(w_tick),
      .i_primed(w_primed[g]), .i_load(w_load[g]),
      .o_sync(w_sync_b[g]), .o_out(w_out_b[g]), .o_upd(w_upd_b[g])
    );

    assign w_primed[g] = (r_state[g] == ST_PRIMED);
    assign w_chg[g]    = (w_sync_a[g] != r_prev_a[g]) || (w_sync_b[g] != r_prev_b[g]);
    assign w_load[g]   = !w_primed[g] && w_tick && !w_chg[g] && (r_pcnt[g] == 8'(DB_TICKS - 1));
    // Decode compares the held pair against the pair being loaded this same edge.
    assign w_quad[g]   = quad_decode({w_out_a[g], w_out_b[g]},
                                     {w_upd_a[g] ? w_sync_a[g] : w_out_a[g],
                                      w_upd_b[g] ? w_sync_b[g] : w_out_b[g]});
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev_a <= '0;
      r_prev_b <= '0;
      r_step   <= '0;
      r_dir    <= '0;
      r_err    <= '0;
      for (int unsigned i = 0; i < NUM_ENC; i++) begin
        r_state[i] <= ST_UNPRIMED;
        r_pcnt[i]  <= '0;
      end
    end else begin
      r_prev_a <= w_sync_a;
      r_prev_b <= w_sync_b;
      for (int unsigned i = 0; i < NUM_ENC; i++) begin
        case (r_state[i])
          ST_UNPRIMED: begin
            r_step[i] <= 1'b0;
            r_err[i]  <= 1'b0;
            if (w_chg[i]) begin
              r_pcnt[i] <= '0;
            end else if (w_load[i]) begin
              r_pcnt[i]  <= '0;
              r_state[i] <= ST_PRIMED;
            end else if (w_tick) begin
              r_pcnt[i] <= r_pcnt[i] + 8'd1;
            end
          end
          ST_PRIMED: begin
            r_step[i] <= w_quad[i].step;
            r_err[i]  <= w_quad[i].err;
            if (w_quad[i].step) r_dir[i] <= w_quad[i].dir_fwd;
          end
        endcase
      end
    end
  end

  assign bus.enc_a_out = w_out_a;
  assign bus.enc_b_out = w_out_b;
  assign bus.step      = r_step;
  assign bus.dir       = r_dir;
  assign bus.err       = r_err;

`ifdef ENC_ERR_COUNT_EN
  logic [7:0] r_errc [NUM_ENC];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_ENC; i++) r_errc[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENC; i++) begin
        if (r_err[i] && (r_errc[i] != 8'hFF)) r_errc[i] <= r_errc[i] + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_ENC; g++) begin : g_errc
    assign bus.err_count[8*g +: 8] = r_errc[g];
  end
`endif

endmodule

// File: tb/tb_enc_conditioner.sv
// Directed bench for enc_conditioner with PRESCALE=1, DB_TICKS=4, SYNC_STAGES=2.
module tb_enc_conditioner;
  localparam int N = 3;
`ifdef ENC_ERR_COUNT_EN
  localparam int NERR = 300;
`else
  localparam int NERR = 6;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  enc_conditioner_if #(.NUM_ENC(N)) bus();

  enc_conditioner #(
    .NUM_ENC(N), .SYNC_STAGES(2), .PRESCALE(1), .DB_TICKS(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int step_cnt [N] = '{default: 0};
  int err_cnt  [N] = '{default: 0};
  int both_cnt = 0;
  int a0_chg   = 0;
  logic a0_prev = 1'b0;

  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (bus.step[c] === 1'b1) step_cnt[c]++;
      if (bus.err[c] === 1'b1) err_cnt[c]++;
      if (bus.step[c] === 1'b1 && bus.err[c] === 1'b1) both_cnt++;
    end
    if (bus.enc_a_out[0] !== a0_prev) begin
      a0_chg++;
      a0_prev = bus.enc_a_out[0];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive channel 0 pins and measure posedges until the debounced pair follows.
  task automatic drive0(input logic a, input logic b, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.enc_a_in[0] = a;
    bus.enc_b_in[0] = b;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && bus.enc_a_out[0] === a && bus.enc_b_out[0] === b) lat = k;
    end
    check(tag, lat, 6);
  endtask

  initial begin
    int s0, s1, s2, e0, e1, e2, c0;

    // Reset with all pins high, then priming
    bus.enc_a_in = '1;
    bus.enc_b_in = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_out", bus.enc_a_out, 0);
    check("rst_b_out", bus.enc_b_out, 0);
    check("rst_step", bus.step, 0);
    check("rst_dir", bus.dir, 0);
    check("rst_err", bus.err, 0);
`ifdef ENC_ERR_COUNT_EN
    check("rst_errcount", bus.err_count, 0);
`endif
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("prime_pending", bus.enc_a_out, 0);
    repeat (15) @(negedge clk);
    check("prime_a_out", bus.enc_a_out, 3'b111);
    check("prime_b_out", bus.enc_b_out, 3'b111);
    check("prime_steps", step_cnt[0] + step_cnt[1] + step_cnt[2], 0);
    check("prime_errs", err_cnt[0] + err_cnt[1] + err_cnt[2], 0);

    // Forward and reverse quadrature on channel 0
    drive0(1'b0, 1'b1, "setup_01");
    drive0(1'b0, 1'b0, "setup_00");
    s0 = step_cnt[0];
    e0 = err_cnt[0];
    drive0(1'b1, 1'b0, "fwd_10");
    drive0(1'b1, 1'b1, "fwd_11");
    drive0(1'b0, 1'b1, "fwd_01");
    drive0(1'b0, 1'b0, "fwd_00");
    check("fwd_steps", step_cnt[0] - s0, 4);
    check("fwd_dir", bus.dir[0], 1);
    check("fwd_errs", err_cnt[0] - e0, 0);
    check("fwd_other_steps", step_cnt[1] + step_cnt[2], 0);
    s0 = step_cnt[0];
    drive0(1'b0, 1'b1, "rev_01");
    drive0(1'b1, 1'b1, "rev_11");
    drive0(1'b1, 1'b0, "rev_10");
    drive0(1'b0, 1'b0, "rev_00");
    check("rev_steps", step_cnt[0] - s0, 4);
    check("rev_dir", bus.dir[0], 0);
    check("rev_errs", err_cnt[0] - e0, 0);

    // Bounce on A: 2-cycle pulses never pass, final level passes once
    s0 = step_cnt[0];
    c0 = a0_chg;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      bus.enc_a_in[0] = (k % 2 == 0);
      repeat (2) @(negedge clk);
    end
    bus.enc_a_in[0] = 1'b1;
    repeat (30) @(negedge clk);
    check("bounce_a_changes", a0_chg - c0, 1);
    check("bounce_steps", step_cnt[0] - s0, 1);
    check("bounce_a_out", bus.enc_a_out[0], 1);
    check("bounce_dir", bus.dir[0], 1);

    // Simultaneous A/B change is illegal; dir holds
    drive0(1'b1, 1'b1, "t4_11");
    drive0(1'b0, 1'b1, "t4_01");
    drive0(1'b0, 1'b0, "t4_00");
    check("t4_dir_before", bus.dir[0], 1);
    s0 = step_cnt[0];
    e0 = err_cnt[0];
    drive0(1'b1, 1'b1, "illegal_lat");
    check("illegal_err", err_cnt[0] - e0, 1);
    check("illegal_step", step_cnt[0] - s0, 0);
    check("illegal_dir", bus.dir[0], 1);

    // Concurrent steps on channels 0 (reverse) and 2 (forward)
    s0 = step_cnt[0];
    s1 = step_cnt[1];
    s2 = step_cnt[2];
    @(negedge clk);
    bus.enc_b_in[0] = 1'b0;
    bus.enc_a_in[2] = 1'b0;
    repeat (20) @(negedge clk);
    check("multi_step0", step_cnt[0] - s0, 1);
    check("multi_step1", step_cnt[1] - s1, 0);
    check("multi_step2", step_cnt[2] - s2, 1);
    check("multi_dir", bus.dir, 3'b100);

    // Reset three cycles into a pending A change on channel 0
    @(negedge clk);
    bus.enc_a_in[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_a_out", bus.enc_a_out, 0);
    check("midrst_b_out", bus.enc_b_out, 0);
    check("midrst_step", bus.step, 0);
    check("midrst_dir", bus.dir, 0);
`ifdef ENC_ERR_COUNT_EN
    check("midrst_errcount", bus.err_count, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    s0 = step_cnt[0] + step_cnt[1] + step_cnt[2];
    e0 = err_cnt[0] + err_cnt[1] + err_cnt[2];
    repeat (25) @(negedge clk);
    check("reprime_a_out", bus.enc_a_out, 3'b010);
    check("reprime_b_out", bus.enc_b_out, 3'b110);
    check("reprime_steps", step_cnt[0] + step_cnt[1] + step_cnt[2] - s0, 0);
    check("reprime_errs", err_cnt[0] + err_cnt[1] + err_cnt[2] - e0, 0);

    // Repeated illegal transitions on channel 1
    e0 = err_cnt[0];
    e1 = err_cnt[1];
    e2 = err_cnt[2];
    s1 = step_cnt[1];
    for (int k = 0; k < NERR; k++) begin
      @(negedge clk);
      bus.enc_a_in[1] = k[0];
      bus.enc_b_in[1] = k[0];
      repeat (7) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("errs_ch1", err_cnt[1] - e1, NERR);
    check("errs_ch1_steps", step_cnt[1] - s1, 0);
    check("errs_ch0", err_cnt[0] - e0, 0);
    check("errs_ch2", err_cnt[2] - e2, 0);
`ifdef ENC_ERR_COUNT_EN
    check("errcount_ch1", bus.err_count[15:8], 8'd255);
    check("errcount_ch0", bus.err_count[7:0], 8'd0);
    check("errcount_ch2", bus.err_count[23:16], 8'd0);
`endif
    check("step_err_overlap", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
